// File: rtl/pulse_sched.sv
// pulse_sched: round-robin scheduler that shares one programmable delay
// timer among N_REQ requesters. The owner holds Gnt while the delay runs;
// at expiry a single-cycle Mo pulse and Ack to the owner are emitted.
// A running delay can be cancelled by Abort or by the owner dropping Req.
//
// Ports
//   Clk    in   rising-edge system clock
//   Clr    in   asynchronous active-high reset
//   Req    in   [N_REQ] level requests, held until Ack
//   Dly    in   [CNT_W] delay in cycles, sampled at grant (0 treated as 1)
//   Abort  in   cancel running delay / block a grant in IDLE
//   Gnt    out  [N_REQ] one-hot owner while the timer runs
//   Ack    out  [N_REQ] one-cycle pulse to the owner at expiry
//   Mo     out  one-cycle pulse at expiry
//   Busy   out  high in RUN and DONE
//   Cnt    out  [CNT_W] running count, 0 outside RUN
module pulse_sched #(
    parameter int N_REQ = 4,
    parameter int CNT_W = 18
) (
    input  logic             Clk,
    input  logic             Clr,
    input  logic [N_REQ-1:0] Req,
    input  logic [CNT_W-1:0] Dly,
    input  logic             Abort,
    output logic [N_REQ-1:0] Gnt,
    output logic [N_REQ-1:0] Ack,
    output logic             Mo,
    output logic             Busy,
    output logic [CNT_W-1:0] Cnt
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state, state_nxt;
    logic [IDX_W-1:0]   ptr, ptr_nxt;
    logic [IDX_W-1:0]   idx, idx_nxt;
    logic [CNT_W-1:0]   d_lat, d_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [N_REQ-1:0]   gnt, gnt_nxt;
    logic [N_REQ-1:0]   ack, ack_nxt;
    logic               mo, mo_nxt;
    logic               busy, busy_nxt;

    logic               pick_vld;
    logic [IDX_W-1:0]   pick_idx;
    logic [IDX_W-1:0]   ptr_inc;

    // First set request at or above ptr, wrapping to 0.
    always_comb begin
        int j;
        j        = 0;
        pick_vld = 1'b0;
        pick_idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            j = int'(ptr) + i;
            if (j >= N_REQ) j = j - N_REQ;
            if (!pick_vld && Req[j]) begin
                pick_vld = 1'b1;
                pick_idx = IDX_W'(j);
            end
        end
    end

    // Pointer always moves past the owner, whether it completed or was cancelled.
    assign ptr_inc = (idx == IDX_W'(N_REQ - 1)) ? '0 : idx + 1'b1;

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        idx_nxt   = idx;
        d_nxt     = d_lat;
        cnt_nxt   = cnt;
        gnt_nxt   = gnt;
        ack_nxt   = '0;
        mo_nxt    = 1'b0;
        busy_nxt  = busy;
        case (state)
            IDLE: begin
                gnt_nxt  = '0;
                cnt_nxt  = '0;
                busy_nxt = 1'b0;
                if (!Abort && pick_vld) begin
                    state_nxt = RUN;
                    idx_nxt   = pick_idx;
                    d_nxt     = (Dly == '0) ? CNT_W'(1) : Dly;
                    gnt_nxt   = N_REQ'(1) << pick_idx;
                    busy_nxt  = 1'b1;
                end
            end
            RUN: begin
                // Cancel is checked first so Abort beats a same-cycle expiry.
                if (Abort || !Req[idx]) begin
                    state_nxt = IDLE;
                    gnt_nxt   = '0;
                    cnt_nxt   = '0;
                    busy_nxt  = 1'b0;
                    ptr_nxt   = ptr_inc;
                end else if (cnt == d_lat - 1'b1) begin
                    state_nxt = DONE;
                    gnt_nxt   = '0;
                    cnt_nxt   = '0;
                    ack_nxt   = gnt;
                    mo_nxt    = 1'b1;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            DONE: begin
                state_nxt = IDLE;
                busy_nxt  = 1'b0;
                ptr_nxt   = ptr_inc;
            end
            default: begin
                state_nxt = IDLE;
                gnt_nxt   = '0;
                cnt_nxt   = '0;
                busy_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge Clk or posedge Clr) begin
        if (Clr) begin
            state <= IDLE;
            ptr   <= '0;
            idx   <= '0;
            d_lat <= '0;
            cnt   <= '0;
            gnt   <= '0;
            ack   <= '0;
            mo    <= 1'b0;
            busy  <= 1'b0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
            idx   <= idx_nxt;
            d_lat <= d_nxt;
            cnt   <= cnt_nxt;
            gnt   <= gnt_nxt;
            ack   <= ack_nxt;
            mo    <= mo_nxt;
            busy  <= busy_nxt;
        end
    end

    assign Gnt  = gnt;
    assign Ack  = ack;
    assign Mo   = mo;
    assign Busy = busy;
    assign Cnt  = cnt;

endmodule
